tree_route_node: RTL

- Parametrised successor to the fixed 2-way leaf decoder in the tree NoC.
- One input channel feeds a DEPTH-entry FIFO. Each packet is classified as local (routed to one of NUM_DOWN child ports) or non-local (routed to the up port).
- Per packet, a select token goes out on the S channel first, then the data word goes to the chosen port, in that order.
- Sits at every internal and leaf node of the address tree; the clocked body sits behind the channel send/receive wrappers.

---
 rtl/tree_route_node_if.sv | 27 ++
 rtl/tree_route_node.sv | 116 +++++++++++
 2 files changed

// File: rtl/tree_route_node_if.sv
// Input, select and output channels of one tree route node.
// The master modport is the node's own view.
interface tree_route_node_if #(
    parameter int DATA_W = 9,
    parameter int SW     = 2,
    parameter int NP     = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              sel_valid;
    logic              sel_ready;
    logic [SW-1:0]     sel_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_valid, in_data, sel_ready, out_ready,
        output in_ready, sel_valid, sel_data, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, sel_ready, out_ready,
        input  in_ready, sel_valid, sel_data, out_valid, out_data
    );
endinterface

// File: rtl/tree_route_node.sv
// Tree NoC route node: buffers packets in a small FIFO, then sends a select
// token on the S channel followed by the packet on the chosen child or up port.
//
//   state | meaning
//   IDLE  | waiting for a FIFO head; latches its route when one appears
//   SEL   | offering the route index on the select channel
//   DATA  | offering the head packet on port route_q; pops on its ready
module tree_route_node #(
    parameter int                DATA_W    = 9,
    parameter int                ADDR_W    = 4,
    parameter int                ADDR_LSB  = 5,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b0010,
    parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1110,
    parameter int                NUM_DOWN  = 2,
    parameter int                CHILD_LSB = 0,
    parameter int                DEPTH     = 4,
    localparam int               CW        = $clog2(NUM_DOWN),
    localparam int               SW        = $clog2(NUM_DOWN + 1),
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              _RESET,
    tree_route_node_if.master bus,
    output logic [AW:0]       fifo_count,
    output logic [15:0]       pkt_count
);
    localparam int              NP       = NUM_DOWN + 1;
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0]   UP_PORT  = SW'(NUM_DOWN);

    typedef enum logic [1:0] {IDLE, SEL, DATA} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count_q;
    logic [SW-1:0]     route_q, route_d, route_head;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] head;
    logic [15:0]       pkt_q;
    logic              full, empty, push, pop;

    assign head  = mem[rd_ptr];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // No bypass: a full FIFO refuses input even while it is being popped.
    assign push  = bus.in_valid && !full;
    assign pop   = (state_q == DATA) && bus.out_ready[route_q];

    assign dst        = head[ADDR_LSB +: ADDR_W];
    assign route_head = ((dst & NODE_MASK) == NODE_ADDR) ? SW'(dst[CHILD_LSB +: CW]) : UP_PORT;

    assign bus.in_ready = !full;
    assign fifo_count   = count_q;
    assign pkt_count    = pkt_q;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET)  pkt_q <= '0;
        else if (pop) pkt_q <= pkt_q + 16'd1;
    end

    always_comb begin
        state_d       = state_q;
        route_d       = route_q;
        bus.sel_valid = 1'b0;
        bus.sel_data  = '0;
        bus.out_valid = '0;
        bus.out_data  = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    route_d = route_head;
                    state_d = SEL;
                end
            end
            SEL: begin
                bus.sel_valid = 1'b1;
                bus.sel_data  = route_q;
                if (bus.sel_ready) state_d = DATA;
            end
            DATA: begin
                bus.out_valid = NP'(1) << route_q;
                bus.out_data  = head;
                if (bus.out_ready[route_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
